lcd_bus_sequencer: RTL
======================

Name: lcd_bus_sequencer

Overview:
- Owns the HD44780-style LCD bus (E, RW, RS, DB[7:0]) of the safe design and runs on the 1 ms tick clock.
- After reset it runs the fixed power-up/init command sequence.
- It then shares the bus between two byte requesters (req0 = keypad echo, req1 = status/message writer) with round-robin arbitration.
- It generates E-pulse timing and post-write settle delays for every byte.

Parameters:
- POWERUP_MS, 20, idle cycles after reset before the first init write (E held low).
- CMD_WAIT, 1, settle cycles after a normal command or data write.
- CLR_WAIT, 2, settle cycles after clear (0x01) or home (0x02) with RS=0.
- FIRST_WAIT, 5, settle cycles after the first init write only.

Ports:
- clk_1ms  in  1  1 ms system clock; all logic rises on its posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req0_valid  in  1  requester 0 has a byte.
- req0_rs  in  1  requester 0 RS value (0 = command, 1 = data).
- req0_data  in  8  requester 0 byte.
- req0_ready  out  1  requester 0 byte accepted this cycle.
- req1_valid / req1_rs / req1_data / req1_ready  same as requester 0, for requester 1.
- init_done  out  1  init sequence complete; sticky until reset.
- busy  out  1  high whenever the state is not IDLE.
- E  out  1  LCD enable.
- RW  out  1  LCD read/write select; constant 0 (write only).
- RS  out  1  LCD register select.
- DB  out  8  LCD data bus.

Behaviour:
- Reset asserted: state PWR_WAIT, counter 0, E=0, RW=0, RS=0, DB=0x00, init_done=0, req*_ready=0, busy=1, rr pointer=1 (req0 wins the first tie). Takes effect immediately, including mid-pulse.
- E, RS and DB are registered. RW is tied 0.
- States: PWR_WAIT, INIT_SETUP, INIT_EHI, INIT_ELO, INIT_WAIT, IDLE, SETUP, EHI, ELO, WAIT.
- PWR_WAIT: count POWERUP_MS cycles, then go to INIT_SETUP with init index 0.
- Init ROM, 7 entries, all RS=0, with settle cycles:
  - 0x38, FIRST_WAIT
  - 0x38, CMD_WAIT
  - 0x38, CMD_WAIT
  - 0x38, CMD_WAIT
  - 0x0C, CMD_WAIT
  - 0x01, CLR_WAIT
  - 0x06, CMD_WAIT
- Write cycle (init and normal are identical):
  - SETUP: DB/RS driven, E=0, 1 cycle.
  - EHI: E=1, 1 cycle.
  - ELO: E=0, DB/RS held, 1 cycle.
  - WAIT: N cycles, then next state.
  - N = CLR_WAIT if RS=0 and byte is 0x01 or 0x02; CMD_WAIT otherwise; FIRST_WAIT for init entry 0.
- After INIT_WAIT of the last ROM entry: init_done=1 and go to IDLE. Otherwise index+1 and go to INIT_SETUP.
- IDLE arbitration (combinational):
  - Only one valid: that requester is granted.
  - Both valid: the requester other than the last-granted one is granted.
  - reqX_ready = (state==IDLE) && grant==X. At most one ready is high per cycle; ready is never high outside IDLE.
- Transfer: valid && ready at a posedge. That edge latches rs/data, updates the rr pointer, and enters SETUP.
- Latency: DB/RS change on the edge after acceptance, E rises one cycle later and is high for exactly 1 cycle.
- Accept-to-accept throughput: 3+N+1 cycles minimum.
- Requests while not IDLE (including during init) are held off (ready=0). Requesters must hold valid/rs/data stable until ready.
- DB/RS keep their last written values in IDLE and WAIT. E is never high outside (INIT_)EHI.
- The 8-bit wait counter saturates-free; it is reloaded on entry to each WAIT.
- A valid dropped before ready is not an error; nothing is latched.
- Reset deasserted while requests are valid: requests are ignored until init_done=1.

Test Plan:
- Reset low 20 ns then high; no requests -> E=0 and busy=1 for 20 cycles. First E pulse has DB=0x38, RS=0, RW=0. Next E rise occurs 5+3 cycles after the first.
- Complete init -> exactly 7 E pulses with DB 0x38,0x38,0x38,0x38,0x0C,0x01,0x06. Gap after 0x01 is one cycle longer than the others. init_done=1 and busy=0 after the last wait.
- After init, req0 valid with rs=1, data=0x41 -> req0_ready high 1 cycle. Next cycle DB=0x41, RS=1. Following cycle E=1 for one cycle. IDLE again 3+1 cycles after acceptance.
- req0 and req1 both held valid (0x31 and 0x32, rs=1) -> DB pulses alternate 0x31,0x32,0x31,… starting with req0. Ready is never high on both at once.
- req1 rs=0 data=0x01 -> wait after E falls is 2 cycles. Then req1 rs=0 data=0x80 -> wait is 1 cycle.
- reset driven low while E=1 mid-write -> E=0, DB=0x00 and init_done=0 immediately. After release the full power-up delay and 7-byte init repeat.

Source files
------------

// File: rtl/lcd_bus_sequencer_if.sv
// Requester handshakes and HD44780-style LCD bus pins shared by the sequencer and its users.
interface lcd_bus_sequencer_if;
  logic       req0_valid;
  logic       req0_rs;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic       req1_rs;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       E;
  logic       RW;
  logic       RS;
  logic [7:0] DB;

  modport master (
    output req0_valid, req0_rs, req0_data,
    output req1_valid, req1_rs, req1_data,
    input  req0_ready, req1_ready,
    input  E, RW, RS, DB
  );

  modport slave (
    input  req0_valid, req0_rs, req0_data,
    input  req1_valid, req1_rs, req1_data,
    output req0_ready, req1_ready,
    output E, RW, RS, DB
  );
endinterface

// File: rtl/lcd_bus_sequencer.sv
// LCD bus owner: power-up delay, fixed init sequence, then round-robin byte writes
// from two requesters with E-pulse generation and per-byte settle delays.
//
// state      | meaning
// PWR_WAIT   | power-up idle, E low, counting POWERUP_MS
// INIT_SETUP | init byte on DB/RS, E low
// INIT_EHI   | init byte, E high
// INIT_ELO   | init byte, E low, settle counter loaded
// INIT_WAIT  | settle after init byte
// IDLE       | arbitration, ready offered to one requester
// SETUP      | requester byte on DB/RS, E low
// EHI        | requester byte, E high
// ELO        | requester byte, E low, settle counter loaded
// WAIT       | settle after requester byte
module lcd_bus_sequencer #(
  parameter int POWERUP_MS = 20,
  parameter int CMD_WAIT   = 1,
  parameter int CLR_WAIT   = 2,
  parameter int FIRST_WAIT = 5
) (
  input  logic               clk_1ms,
  input  logic               reset,
  lcd_bus_sequencer_if.slave lcd,
  output logic               init_done,
  output logic               busy
);

  typedef enum logic [3:0] {
    PWR_WAIT,
    INIT_SETUP,
    INIT_EHI,
    INIT_ELO,
    INIT_WAIT,
    IDLE,
    SETUP,
    EHI,
    ELO,
    WAIT
  } state_t;

  localparam logic [2:0] INIT_LAST = 3'd6;

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [2:0] idx_q;
  logic       e_q;
  logic       rs_q;
  logic [7:0] db_q;
  logic       init_done_q;
  logic       last_q;

  logic       grant_vld_d;
  logic       grant_sel_d;
  logic       is_idle;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: init_byte = 8'h38;
      3'd4:                   init_byte = 8'h0C;
      3'd5:                   init_byte = 8'h01;
      default:                init_byte = 8'h06;
    endcase
  endfunction

  // Clear and home are the slow commands; everything else settles in CMD_WAIT.
  function automatic logic [7:0] settle(input logic rs, input logic [7:0] b);
    if (!rs && (b == 8'h01 || b == 8'h02)) settle = 8'(CLR_WAIT);
    else                                   settle = 8'(CMD_WAIT);
  endfunction

  assign is_idle = (state_q == IDLE);

  // Round robin: on a tie the requester other than the last-granted one wins.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_sel_d = 1'b0;
    if (lcd.req0_valid && lcd.req1_valid) begin
      grant_vld_d = 1'b1;
      grant_sel_d = ~last_q;
    end else if (lcd.req0_valid) begin
      grant_vld_d = 1'b1;
      grant_sel_d = 1'b0;
    end else if (lcd.req1_valid) begin
      grant_vld_d = 1'b1;
      grant_sel_d = 1'b1;
    end
  end

  always_ff @(posedge clk_1ms or negedge reset) begin
    if (!reset) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= 8'd0;
      idx_q       <= 3'd0;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      db_q        <= 8'h00;
      init_done_q <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      case (state_q)
        PWR_WAIT: begin
          if (cnt_q == 8'(POWERUP_MS - 1)) begin
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            db_q    <= init_byte(3'd0);
            rs_q    <= 1'b0;
            state_q <= INIT_SETUP;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        INIT_SETUP: begin
          e_q     <= 1'b1;
          state_q <= INIT_EHI;
        end
        INIT_EHI: begin
          e_q     <= 1'b0;
          state_q <= INIT_ELO;
        end
        INIT_ELO: begin
          cnt_q   <= (idx_q == 3'd0) ? 8'(FIRST_WAIT) : settle(rs_q, db_q);
          state_q <= INIT_WAIT;
        end
        INIT_WAIT: begin
          if (cnt_q <= 8'd1) begin
            cnt_q <= 8'd0;
            if (idx_q == INIT_LAST) begin
              init_done_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              idx_q   <= idx_q + 3'd1;
              db_q    <= init_byte(idx_q + 3'd1);
              rs_q    <= 1'b0;
              state_q <= INIT_SETUP;
            end
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        IDLE: begin
          // A granted valid is a transfer, since ready equals grant in IDLE.
          if (grant_vld_d) begin
            last_q  <= grant_sel_d;
            db_q    <= grant_sel_d ? lcd.req1_data : lcd.req0_data;
            rs_q    <= grant_sel_d ? lcd.req1_rs   : lcd.req0_rs;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          e_q     <= 1'b1;
          state_q <= EHI;
        end
        EHI: begin
          e_q     <= 1'b0;
          state_q <= ELO;
        end
        ELO: begin
          cnt_q   <= settle(rs_q, db_q);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q <= 8'd1) begin
            cnt_q   <= 8'd0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: begin
          e_q     <= 1'b0;
          state_q <= PWR_WAIT;
        end
      endcase
    end
  end

  assign lcd.E          = e_q;
  assign lcd.RW         = 1'b0;
  assign lcd.RS         = rs_q;
  assign lcd.DB         = db_q;
  assign lcd.req0_ready = is_idle && grant_vld_d && !grant_sel_d;
  assign lcd.req1_ready = is_idle && grant_vld_d &&  grant_sel_d;
  assign init_done      = init_done_q;
  assign busy           = !is_idle;

endmodule
